div_issue_ctrl: RTL and testbench

EX-stage requester for the team's iterative 32-bit radix-2 divider. It decodes DIV/DIVU in EX and latches the operands. It drives the divider's start/annul/signed/operand inputs and stalls the pipeline until the divider reports ready. It then delivers remainder/quotient to HI/LO as a one-cycle write, and drains the divider safely after a pipeline flush so a stale result is never consumed.

---
 rtl/div_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/complete controller for the iterative radix-2 divider: latches operands,
// holds start while waiting for ready, writes HI/LO once, and drains the divider after a flush.
module div_issue_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_i,
    input  logic        divu_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        flush_i,
    input  logic        ready_i,
    input  logic [63:0] result_i,
    output logic        signed_div_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    output logic        start_o,
    output logic        annul_o,
    output logic        stall_req_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | no divide in flight; evaluates a div in EX
    // WAIT  | start held high until the divider reports ready
    // DONE  | single HI/LO write cycle, start dropped
    // ABORT | start held low for DRAIN_CYCLES so the divider returns to free
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ABORT} state_t;

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_op1;
    logic [31:0]     r_op2;
    logic            r_signed;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic            w_req;
    logic            w_issue;
    logic            w_capture;
    logic            w_abort;

    // rst gates the request so the combinational stall is low while reset is held
    assign w_req     = (div_i | divu_i) & ~flush_i & rst;
    assign w_issue   = (r_state == S_IDLE) & w_req;
    assign w_capture = (r_state == S_WAIT) & ~flush_i & ready_i;
    assign w_abort   = (r_state == S_WAIT) & flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_op1    <= rs_data_i;
                r_op2    <= rt_data_i;
                r_signed <= div_i;
            end
            if (w_capture) begin
                r_hi <= result_i[63:32];
                r_lo <= result_i[31:0];
            end
            if (w_abort) begin
                r_cnt <= CW'(DRAIN_CYCLES);
            end else if (r_state == S_ABORT) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        start_o     = 1'b0;
        annul_o     = 1'b0;
        stall_req_o = 1'b0;
        hilo_we_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_req_o = w_req;
                if (w_req) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                start_o     = 1'b1;
                stall_req_o = 1'b1;
                if (flush_i) begin
                    annul_o = 1'b1;
                    w_next  = S_ABORT;
                end else if (ready_i) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                hilo_we_o = ~flush_i;
                w_next    = S_IDLE;
            end
            S_ABORT: begin
                stall_req_o = w_req;
                if (r_cnt <= CW'(1)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign signed_div_o = r_signed;
    assign opdata1_o    = r_op1;
    assign opdata2_o    = r_op2;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural divider with programmable latency, arithmetic
// reference for quotient/remainder, directed scenarios followed by randomized divides.
module tb_div_issue_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_i, divu_i, flush_i, ready_i;
    logic [31:0] rs_data_i, rt_data_i;
    logic [63:0] result_i;
    logic        signed_div_o, start_o, annul_o, stall_req_o, hilo_we_o, busy_o;
    logic [31:0] opdata1_o, opdata2_o, hi_o, lo_o;

    int n_chk = 0;
    int n_err = 0;
    int lat   = 0;
    int dcnt  = 0;

    div_issue_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst), .div_i(div_i), .divu_i(divu_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .flush_i(flush_i),
        .ready_i(ready_i), .result_i(result_i), .signed_div_o(signed_div_o),
        .opdata1_o(opdata1_o), .opdata2_o(opdata2_o), .start_o(start_o),
        .annul_o(annul_o), .stall_req_o(stall_req_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // {remainder, quotient}, truncating division; divide-by-zero yields zero
    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Divider: ready rises lat+1 edges after start is seen, stays while start is held
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_i  <= 1'b0;
            result_i <= 64'd0;
            dcnt     <= 0;
        end else if (start_o && !annul_o) begin
            if (dcnt >= lat) begin
                ready_i  <= 1'b1;
                result_i <= ref_div(signed_div_o, opdata1_o, opdata2_o);
            end else begin
                dcnt <= dcnt + 1;
            end
        end else begin
            ready_i <= 1'b0;
            dcnt    <= 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, start_o, 0);
        check({tag, "_annul"}, annul_o, 0);
        check({tag, "_stall"}, stall_req_o, 0);
        check({tag, "_hilo_we"}, hilo_we_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_hi"}, hi_o, 0);
        check({tag, "_lo"}, lo_o, 0);
        check({tag, "_op1"}, opdata1_o, 0);
        check({tag, "_op2"}, opdata2_o, 0);
        check({tag, "_signed"}, signed_div_o, 0);
    endtask

    // Issue from IDLE, follow WAIT cycle by cycle, check DONE and the cycle after
    task automatic run_op(input bit sd, input bit ud, input logic [31:0] a, input logic [31:0] b,
                          input int l, input bit fl_done, input string tag);
        logic [63:0] exp;
        int waits;
        bit seen;
        exp = ref_div(sd, a, b);
        lat = l;
        @(negedge clk);
        div_i = sd; divu_i = ud; rs_data_i = a; rt_data_i = b; flush_i = 1'b0;
        #1;
        check({tag, "_idle_busy"}, busy_o, 0);
        check({tag, "_issue_stall"}, stall_req_o, 1);
        check({tag, "_idle_start"}, start_o, 0);
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!start_o) begin
                seen = 1'b1;
            end else begin
                waits++;
                check({tag, "_wait_op1"}, opdata1_o, a);
                check({tag, "_wait_op2"}, opdata2_o, b);
                check({tag, "_wait_signed"}, signed_div_o, sd);
                check({tag, "_wait_stall"}, stall_req_o, 1);
                check({tag, "_wait_annul"}, annul_o, 0);
                check({tag, "_wait_hilo_we"}, hilo_we_o, 0);
            end
        end
        if (!seen) begin
            n_chk++; n_err++;
            $error("FAIL %s_timeout: got start_o=1 after 200 cycles expected drop", tag);
            return;
        end
        check({tag, "_wait_len"}, waits, l + 2);
        check({tag, "_done_busy"}, busy_o, 1);
        check({tag, "_done_stall"}, stall_req_o, 0);
        if (fl_done) begin
            flush_i = 1'b1;
            #1;
            check({tag, "_done_flush_we"}, hilo_we_o, 0);
        end else begin
            check({tag, "_done_we"}, hilo_we_o, 1);
            check({tag, "_hi"}, hi_o, exp[63:32]);
            check({tag, "_lo"}, lo_o, exp[31:0]);
        end
        div_i = 1'b0; divu_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check({tag, "_after_busy"}, busy_o, 0);
        check({tag, "_after_we"}, hilo_we_o, 0);
        check({tag, "_after_start"}, start_o, 0);
        if (!fl_done) check({tag, "_after_lo_hold"}, lo_o, exp[31:0]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] ra, rb;
        bit rsd;
        rst = 1'b0; div_i = 1'b0; divu_i = 1'b0; flush_i = 1'b0;
        rs_data_i = 32'd0; rt_data_i = 32'd0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        run_op(0, 1, 32'd100, 32'd7, 3, 0, "t1");
        check("t1_lo_const", lo_o, 32'd14);
        check("t1_hi_const", hi_o, 32'd2);
        run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 5, 0, "t2");
        check("t2_hi_const", hi_o, 32'hFFFF_FFFF);
        check("t2_lo_const", lo_o, 32'hFFFF_FFFD);
        run_op(0, 1, 32'd123, 32'd0, 1, 0, "t3z");
        run_op(0, 1, 32'd1000, 32'd3, 0, 0, "t3n");
        run_op(1, 1, 32'hFFFF_FF00, 32'd16, 2, 0, "both");

        // flush 10 cycles into WAIT with DIVU 50/5 following in EX
        lat = 40;
        @(negedge clk);
        div_i = 1'b0; divu_i = 1'b1; rs_data_i = 32'd1000; rt_data_i = 32'd3;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check("t4_annul", annul_o, 1);
        check("t4_flush_start", start_o, 1);
        check("t4_flush_we", hilo_we_o, 0);
        @(negedge clk);
        flush_i = 1'b0; rs_data_i = 32'd50; rt_data_i = 32'd5;
        for (int i = 0; i < DRAIN; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("t4_abort_busy", busy_o, 1);
            check("t4_abort_start", start_o, 0);
            check("t4_abort_annul", annul_o, 0);
            check("t4_abort_stall", stall_req_o, 1);
            check("t4_abort_we", hilo_we_o, 0);
        end
        run_op(0, 1, 32'd50, 32'd5, 4, 0, "t4");
        check("t4_lo_const", lo_o, 32'd10);
        check("t4_hi_const", hi_o, 32'd0);

        // ready and flush in the same cycle
        lat = 3;
        @(negedge clk);
        divu_i = 1'b1; rs_data_i = 32'd77; rt_data_i = 32'd4;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (ready_i) found = 1'b1;
        end
        check("t5_ready_seen", found, 1);
        flush_i = 1'b1;
        #1;
        check("t5_annul", annul_o, 1);
        check("t5_we", hilo_we_o, 0);
        @(negedge clk);
        flush_i = 1'b0; divu_i = 1'b0;
        #1;
        check("t5_abort_busy", busy_o, 1);
        check("t5_abort_we", hilo_we_o, 0);
        check("t5_lo_kept", lo_o, 32'd10);
        check("t5_hi_kept", hi_o, 32'd0);
        repeat (DRAIN) @(negedge clk);
        check("t5_idle", busy_o, 0);
        run_op(0, 1, 32'd81, 32'd9, 2, 1, "t5done");

        // asynchronous reset in the middle of WAIT
        lat = 20;
        @(negedge clk);
        divu_i = 1'b1; rs_data_i = 32'd1000; rt_data_i = 32'd7;
        repeat (5) @(negedge clk);
        check("t6_pre_busy", busy_o, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk);
        divu_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(0, 1, 32'd9, 32'd3, 2, 0, "t6");

        for (int k = 0; k < 12; k++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: rb = $urandom;
            endcase
            run_op(rsd, ~rsd, ra, rb, $urandom_range(0, 12), ($urandom_range(0, 5) == 0), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
